// File: rtl/tanh_share_ctrl.sv
// Round-robin front end that time-shares one external pipelined tanh unit between
// NUM_REQ requesters and returns each result tagged with the issuing requester.
module tanh_share_ctrl #(
  parameter int BITWIDTH     = 18,
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = 2,
  parameter int TANH_LATENCY = 4,
  parameter int ISSUE_GAP    = 1
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_operand_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [BITWIDTH-1:0]          tanh_operand_o,
  input  logic [BITWIDTH-1:0]          tanh_result_i,
  output logic                         rsp_valid_o,
  output logic [ID_WIDTH-1:0]          rsp_id_o,
  output logic [BITWIDTH-1:0]          rsp_result_o,
  output logic                         busy_o
);

  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [BITWIDTH-1:0] operand_q, operand_d;
  logic [BITWIDTH-1:0] grant_op;
  logic [ID_WIDTH-1:0] grant_id;
  logic [NUM_REQ-1:0]  valid_rot;
  logic                grant_found;
  logic                issue;
  int                  grant_sel;
  int                  grant_k;

  logic [TANH_LATENCY-1:0] tag_vld_q;
  logic [ID_WIDTH-1:0]     tag_id_q [TANH_LATENCY];
  logic                    rsp_valid_q;
  logic [ID_WIDTH-1:0]     rsp_id_q;
  logic [BITWIDTH-1:0]     rsp_result_q;

  // Rotate so bit 0 is the requester at the RR pointer; lowest set bit wins.
  always_comb begin
    valid_rot   = NUM_REQ'({req_valid_i, req_valid_i} >> ptr_q);
    grant_found = 1'b0;
    grant_sel   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && valid_rot[i]) begin
        grant_found = 1'b1;
        grant_sel   = i;
      end
    end
    grant_k = int'(ptr_q) + grant_sel;
    if (grant_k >= NUM_REQ) grant_k = grant_k - NUM_REQ;
    grant_id    = ID_WIDTH'(grant_k);
    issue       = grant_found && !reset_i && (gap_q == '0);
    req_ready_o = issue ? (NUM_REQ'(1) << grant_k) : '0;
    grant_op    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req_ready_o[j]) grant_op = req_operand_i[j*BITWIDTH +: BITWIDTH];
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    gap_d     = gap_q;
    operand_d = operand_q;
    if (issue) begin
      operand_d = grant_op;
      gap_d     = GAP_W'(ISSUE_GAP - 1);
      ptr_d     = (grant_k == NUM_REQ - 1) ? '0 : ID_WIDTH'(grant_k + 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ptr_q        <= '0;
      gap_q        <= '0;
      operand_q    <= '0;
      tag_vld_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      gap_q        <= gap_d;
      operand_q    <= operand_d;
      tag_vld_q[0] <= issue;
      for (int i = 1; i < TANH_LATENCY; i++) tag_vld_q[i] <= tag_vld_q[i-1];
      rsp_valid_q  <= tag_vld_q[TANH_LATENCY-1];
      if (tag_vld_q[TANH_LATENCY-1]) begin
        rsp_id_q     <= tag_id_q[TANH_LATENCY-1];
        rsp_result_q <= tanh_result_i;
      end
    end
  end

  // IDs are only meaningful alongside their valid bit, so they need no reset.
  always_ff @(posedge clock_i) begin
    tag_id_q[0] <= grant_id;
    for (int i = 1; i < TANH_LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
  end

  assign tanh_operand_o = operand_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_id_o       = rsp_id_q;
  assign rsp_result_o   = rsp_result_q;
  assign busy_o         = (|tag_vld_q) | rsp_valid_q;

endmodule

// File: tb/tb_tanh_share_ctrl.sv
// Bench for tanh_share_ctrl: a fully pipelined instance (A) and a gap-5 instance (B),
// each fed by an input+1 stub, checked every cycle against a transaction scoreboard.
module tb_tanh_share_ctrl;
  localparam int TL    = 4;
  localparam int GAP_A = 1;
  localparam int GAP_B = 5;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [17:0] res;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  va, vb;
  logic [17:0] opa [4];
  logic [17:0] opb [4];
  logic [71:0] opa_flat, opb_flat;
  assign opa_flat = {opa[3], opa[2], opa[1], opa[0]};
  assign opb_flat = {opb[3], opb[2], opb[1], opb[0]};

  logic [3:0]  rdy_a, rdy_b;
  logic [17:0] top_a, top_b;
  logic        rv_a, rv_b, busy_a, busy_b;
  logic [1:0]  rid_a, rid_b;
  logic [17:0] rres_a, rres_b;

  // Stub tanh units: result of an operand set at edge n is sampled at edge n+TL.
  logic [17:0] sa1 = '0, sa2 = '0, sa3 = '0;
  logic [17:0] sb1 = '0, sb2 = '0, sb3 = '0;
  always @(posedge clk) begin
    sa1 <= top_a + 18'd1; sa2 <= sa1; sa3 <= sa2;
    sb1 <= top_b + 18'd1; sb2 <= sb1; sb3 <= sb2;
  end

  tanh_share_ctrl #(.BITWIDTH(18), .NUM_REQ(4), .ID_WIDTH(2), .TANH_LATENCY(TL), .ISSUE_GAP(GAP_A)) u_dut_a (
    .clock_i(clk), .reset_i(rst), .req_valid_i(va), .req_operand_i(opa_flat),
    .req_ready_o(rdy_a), .tanh_operand_o(top_a), .tanh_result_i(sa3),
    .rsp_valid_o(rv_a), .rsp_id_o(rid_a), .rsp_result_o(rres_a), .busy_o(busy_a));

  tanh_share_ctrl #(.BITWIDTH(18), .NUM_REQ(4), .ID_WIDTH(2), .TANH_LATENCY(TL), .ISSUE_GAP(GAP_B)) u_dut_b (
    .clock_i(clk), .reset_i(rst), .req_valid_i(vb), .req_operand_i(opb_flat),
    .req_ready_o(rdy_b), .tanh_operand_o(top_b), .tanh_result_i(sb3),
    .rsp_valid_o(rv_b), .rsp_id_o(rid_b), .rsp_result_o(rres_b), .busy_o(busy_b));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t        sb [2][$];
  int          ptr_m [2];
  int          gap_m [2];
  logic [17:0] op_m [2];
  logic [1:0]  lid_m [2];
  logic [17:0] lres_m [2];
  logic [3:0]  erdy [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rr_pick(input logic [3:0] v, input int p);
    logic [3:0] r;
    int j;
    r = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      j = (p + i) % 4;
      if (r == 4'b0000 && v[j[1:0]]) r = 4'b0001 << j;
    end
    return r;
  endfunction

  // One clock: check grant before the edge, advance the model, check outputs after it.
  task automatic cycle();
    logic [3:0]  vld, rdy;
    logic [17:0] op;
    int          k;
    exp_t        e;
    logic        exp_v;
    #1;
    for (int d = 0; d < 2; d++) begin
      vld     = (d == 0) ? va : vb;
      rdy     = (d == 0) ? rdy_a : rdy_b;
      erdy[d] = (!rst && gap_m[d] == 0) ? rr_pick(vld, ptr_m[d]) : 4'b0000;
      chk((d == 0) ? "a_req_ready" : "b_req_ready", 32'(rdy), 32'(erdy[d]));
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        ptr_m[d] = 0; gap_m[d] = 0; op_m[d] = '0; lid_m[d] = '0; lres_m[d] = '0;
        sb[d].delete();
      end else if (erdy[d] != 4'b0000) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (erdy[d][i]) k = i;
        op       = (d == 0) ? opa[k] : opb[k];
        op_m[d]  = op;
        e.due    = cyc + TL;
        e.id     = 2'(k);
        e.res    = op + 18'd1;
        sb[d].push_back(e);
        ptr_m[d] = (k + 1) % 4;
        gap_m[d] = ((d == 0) ? GAP_A : GAP_B) - 1;
      end else if (gap_m[d] > 0) begin
        gap_m[d]--;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_v = 1'b0;
      if (sb[d].size() > 0 && sb[d][0].due == cyc) begin
        e = sb[d].pop_front();
        exp_v = 1'b1;
        lid_m[d] = e.id;
        lres_m[d] = e.res;
      end
      if (d == 0) begin
        chk("a_rsp_valid", 32'(rv_a), 32'(exp_v));
        chk("a_rsp_id", 32'(rid_a), 32'(lid_m[0]));
        chk("a_rsp_result", 32'(rres_a), 32'(lres_m[0]));
        chk("a_tanh_operand", 32'(top_a), 32'(op_m[0]));
        chk("a_busy", 32'(busy_a), 32'(exp_v || sb[0].size() > 0));
      end else begin
        chk("b_rsp_valid", 32'(rv_b), 32'(exp_v));
        chk("b_rsp_id", 32'(rid_b), 32'(lid_m[1]));
        chk("b_rsp_result", 32'(rres_b), 32'(lres_m[1]));
        chk("b_tanh_operand", 32'(top_b), 32'(op_m[1]));
        chk("b_busy", 32'(busy_b), 32'(exp_v || sb[1].size() > 0));
      end
    end
  endtask

  task automatic expect_rdy_a(input string tag, input logic [3:0] e);
    #1;
    chk(tag, 32'(rdy_a), 32'(e));
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      opa[k] = 18'(16 * (k + 1));
      opb[k] = 18'h20000 | 18'(k);
      ptr_m[k % 2] = 0; gap_m[k % 2] = 0; op_m[k % 2] = '0; lid_m[k % 2] = '0; lres_m[k % 2] = '0;
    end
    // Reset held two edges with every requester asking.
    rst = 1'b1; va = 4'hF; vb = 4'hF;
    cycle(); cycle();
    rst = 1'b0; vb = 4'h0;
    chk("t1_operand_after_reset", 32'(top_a), 32'h0);
    chk("t1_busy_after_reset", 32'(busy_a), 32'h0);
    expect_rdy_a("t1_first_grant", 4'b0001);
    // All four continuously: back-to-back RR grants and continuous responses.
    for (int i = 0; i < 12; i++) cycle();
    chk("t3_rsp_stream", 32'(rv_a), 32'h1);
    va = 4'h0;
    for (int i = 0; i < 5; i++) cycle();
    // Lone requester 2 with a known operand.
    opa[2] = 18'h00800; va = 4'b0100;
    cycle();
    chk("t2_operand", 32'(top_a), 32'h00800);
    va = 4'h0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t2_no_early_rsp", 32'(rv_a), 32'h0);
    chk("t2_busy_inflight", 32'(busy_a), 32'h1);
    cycle();
    chk("t2_rsp_valid", 32'(rv_a), 32'h1);
    chk("t2_rsp_id", 32'(rid_a), 32'h2);
    chk("t2_rsp_result", 32'(rres_a), 32'h00801);
    cycle();
    chk("t2_rsp_pulse", 32'(rv_a), 32'h0);
    chk("t2_rsp_hold", 32'(rres_a), 32'h00801);
    // Gap-5 instance, requesters 0 and 1 continuously.
    vb = 4'b0011;
    for (int i = 0; i < 16; i++) cycle();
    vb = 4'h0;
    for (int i = 0; i < 6; i++) cycle();
    // Pointer at 2 after a grant to 1, then 1/3 and later 0 join.
    opa[3] = 18'h3FFFF;
    va = 4'b0010; expect_rdy_a("t5_grant1", 4'b0010); cycle();
    va = 4'b1010; expect_rdy_a("t5_grant3", 4'b1000); cycle();
    expect_rdy_a("t5_then1", 4'b0010); cycle();
    va = 4'b1011; expect_rdy_a("t5_again3", 4'b1000); cycle();
    expect_rdy_a("t5_zero_before1", 4'b0001); cycle();
    expect_rdy_a("t5_then1_again", 4'b0010); cycle();
    va = 4'h0;
    for (int i = 0; i < 5; i++) cycle();
    // Reset two edges after an issue drops the in-flight result.
    va = 4'b0001; cycle();
    va = 4'h0; cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; cycle(); cycle();
    chk("t6_dropped_rsp", 32'(rv_a), 32'h0);
    chk("t6_busy_cleared", 32'(busy_a), 32'h0);
    va = 4'hF; expect_rdy_a("t6_ptr_reset", 4'b0001); cycle();
    va = 4'h0;
    for (int i = 0; i < 6; i++) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tanh_share_ctrl.md
Name: tanh_share_ctrl

Overview:
Round-robin scheduler that shares one pipelined tanh unit (BITWIDTH-bit fixed-point in/out) between NUM_REQ requesters, such as the LSTM cell-candidate and output-gate paths.
- Accepts operands through a valid/ready handshake and drives the shared unit's operand input.
- Carries a requester tag down a shadow pipeline matched to the unit latency.
- Returns each result tagged with the ID of the requester that issued it.
- Sits between the gate datapaths and the single tanh instance; the tanh instance stays outside this block.

Parameters:
BITWIDTH, 18, operand/result width (two's-complement fixed point, passed through unchanged)
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 2, width of the requester ID (>= clog2(NUM_REQ))
TANH_LATENCY, 4, edges from tanh_operand update to valid tanh_result (>= 1)
ISSUE_GAP, 1, minimum edges between successive issues (1 = fully pipelined unit; set to TANH_LATENCY+1 for a non-pipelined unit)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_operand  in  NUM_REQ*BITWIDTH  flattened operands; requester k at [k*BITWIDTH +: BITWIDTH]
req_ready  out  NUM_REQ  one-hot grant; transfer on req_valid[k] & req_ready[k] at the rising edge
tanh_operand  out  BITWIDTH  registered operand to the shared tanh unit
tanh_result  in  BITWIDTH  result from the shared tanh unit
rsp_valid  out  1  one-cycle pulse, result available
rsp_id  out  ID_WIDTH  requester ID of the returned result
rsp_result  out  BITWIDTH  returned tanh value
busy  out  1  any operation in flight

Behaviour:
- Reset (synchronous, sampled at the edge): tanh_operand=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0. RR pointer=0, gap counter=0, all tag-pipeline valid bits cleared.
- Reset mid-operation: in-flight transactions are dropped. No rsp_valid is produced for them even when tanh_result later carries their value.
- Issue allowed: reset=0 and gap counter==0.
- Grant (combinational):
  - When issue is allowed, search req_valid starting at the RR pointer and wrapping modulo NUM_REQ.
  - The first asserted requester k gets req_ready[k]=1; all other ready bits are 0.
  - req_ready is never asserted for a requester whose req_valid is low.
  - When no request is pending or issue is not allowed, req_ready=0.
- Issue edge n (handshake completes):
  - tanh_operand <= operand k.
  - Tag stage 0 <= {valid=1, id=k}.
  - RR pointer <= (k+1) mod NUM_REQ.
  - Gap counter <= ISSUE_GAP-1.
- Non-issue edge:
  - tanh_operand holds its value.
  - Tag stage 0 valid <= 0.
  - Gap counter decrements while nonzero.
  - RR pointer unchanged.
- Tag pipeline: TANH_LATENCY stages, shifting every edge, with no stalls.
- Return: at edge n+TANH_LATENCY, rsp_valid <= last-stage valid, rsp_id <= last-stage id, rsp_result <= tanh_result.
  - Handshake-to-rsp_valid latency is exactly TANH_LATENCY edges.
  - Results return in issue order.
- rsp_valid is high for one cycle per transaction. There is no backpressure; consumers must accept every result.
- rsp_id and rsp_result hold their last value while rsp_valid=0.
- busy = OR of all tag-stage valid bits and rsp_valid (registered terms only).
- Throughput: one issue per ISSUE_GAP edges; fairness means each waiting requester is served within NUM_REQ grants.
- A requester dropping req_valid before a grant is permitted; no state changes for it.
- Values are passed unchanged: no rounding, saturation or sign handling.

Test Plan:
1. Hold reset for 2 edges with all req_valid=1 -> req_ready=0 throughout; after release tanh_operand=0, rsp_valid=0, busy=0, and the first grant goes to requester 0.
2. Requester 2 alone offers 18'h00800 at edge n, stub tanh returns input+1 after 4 edges -> tanh_operand=18'h00800 after edge n; rsp_valid=1, rsp_id=2, rsp_result=18'h00801 after edge n+4 only; busy high from n through n+4.
3. All 4 requesters valid continuously, ISSUE_GAP=1, operands 18'h00010*(k+1) -> grants 0,1,2,3,0,… on consecutive edges; rsp_id follows the same sequence with matching results; rsp_valid stays high continuously.
4. ISSUE_GAP=5, requesters 0 and 1 valid continuously -> issues exactly every 5 edges alternating 0,1; req_ready=0 in the 4 cycles between issues.
5. RR pointer at 2 (previous grant to 1), requesters 1 and 3 valid -> grant 3 then 1; requester 0 asserting later is granted before 1 again.
6. Issue at edge n, reset asserted at edge n+2 for 1 cycle -> no rsp_valid at edge n+4; next grant starts from requester 0.
